// File: rtl/conv16to8bit.sv
// conv16to8bit: serializes 16-bit game-state words into bytes for a UART TX.
// Each link session opens with one sync keyword byte. It then streams MSB/LSB
// pairs back-to-back for as long as the link is enabled, so the far-end
// receiver stays locked. Bytes are handed over one at a time with a
// tx_start/tx_done handshake. A watchdog abandons a byte whose tx_done never
// arrives.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | link disabled or session aborted; nothing in flight
// KEY   | sync keyword issued, waiting for tx_done
// MSB   | high byte of the held word issued, waiting for tx_done
// LSB   | low byte of the held word issued, waiting for tx_done

module conv16to8bit #(
    parameter logic [7:0]  KEYWORD      = 8'h0F,
    parameter logic [15:0] DONE_TIMEOUT = 16'd50000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [15:0] i_din,
    input  logic        i_tx_done,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    output logic        o_synced,
    output logic        o_frame_done,
    output logic        o_tx_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_KEY  = 2'd1,
        ST_MSB  = 2'd2,
        ST_LSB  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_hold;
    logic [15:0] w_hold_nxt;
    logic [15:0] r_wdog;
    logic [15:0] w_wdog_nxt;
    logic [7:0]  r_tx_data;
    logic [7:0]  w_tx_data_nxt;
    logic        r_tx_start;
    logic        w_tx_start_nxt;
    logic        r_synced;
    logic        w_synced_nxt;
    logic        r_frame_done;
    logic        w_frame_done_nxt;
    logic        r_tx_err;
    logic        w_tx_err_nxt;

    logic        w_done;
    logic        w_expire;

    // A tx_done that lands in the same cycle as our own tx_start belongs to
    // no byte of ours, so it is discarded here rather than in every state.
    assign w_done   = i_tx_done & ~r_tx_start;
    assign w_expire = (r_wdog == (DONE_TIMEOUT - 16'd1));

    // Next-state, byte selection and watchdog update.
    always_comb begin
        w_state_nxt      = r_state;
        w_hold_nxt       = r_hold;
        w_tx_data_nxt    = r_tx_data;
        w_tx_start_nxt   = 1'b0;
        w_synced_nxt     = r_synced;
        w_frame_done_nxt = 1'b0;
        w_tx_err_nxt     = 1'b0;
        w_wdog_nxt       = r_wdog;

        if ((r_state != ST_IDLE) && !w_done) begin
            w_wdog_nxt = r_wdog + 16'd1;
        end

        case (r_state)
            ST_IDLE: begin
                if (i_en) begin
                    w_state_nxt    = ST_KEY;
                    w_tx_data_nxt  = KEYWORD;
                    w_tx_start_nxt = 1'b1;
                end
            end
            ST_KEY: begin
                if (w_done) begin
                    if (i_en) begin
                        w_state_nxt    = ST_MSB;
                        w_hold_nxt     = i_din;
                        w_tx_data_nxt  = i_din[15:8];
                        w_tx_start_nxt = 1'b1;
                        w_synced_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_MSB: begin
                // The pair is always completed, even if en has dropped,
                // so the receiver never sees half a word.
                if (w_done) begin
                    w_state_nxt    = ST_LSB;
                    w_tx_data_nxt  = r_hold[7:0];
                    w_tx_start_nxt = 1'b1;
                end
            end
            ST_LSB: begin
                if (w_done) begin
                    w_frame_done_nxt = 1'b1;
                    if (i_en) begin
                        w_state_nxt    = ST_MSB;
                        w_hold_nxt     = i_din;
                        w_tx_data_nxt  = i_din[15:8];
                        w_tx_start_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_synced_nxt = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A late tx_done still wins over an expiry in the same cycle.
        if ((r_state != ST_IDLE) && !w_done && w_expire) begin
            w_state_nxt  = ST_IDLE;
            w_tx_err_nxt = 1'b1;
            w_synced_nxt = 1'b0;
        end

        if (w_tx_start_nxt || (w_state_nxt == ST_IDLE)) begin
            w_wdog_nxt = 16'd0;
        end
    end

    // State and output registers; reset aborts any byte in flight at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_hold       <= 16'd0;
            r_wdog       <= 16'd0;
            r_tx_data    <= 8'h00;
            r_tx_start   <= 1'b0;
            r_synced     <= 1'b0;
            r_frame_done <= 1'b0;
            r_tx_err     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_hold       <= w_hold_nxt;
            r_wdog       <= w_wdog_nxt;
            r_tx_data    <= w_tx_data_nxt;
            r_tx_start   <= w_tx_start_nxt;
            r_synced     <= w_synced_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_tx_err     <= w_tx_err_nxt;
        end
    end

    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_synced     = r_synced;
    assign o_frame_done = r_frame_done;
    assign o_tx_err     = r_tx_err;

endmodule

// File: tb/tb_conv16to8bit.sv
// Testbench for conv16to8bit: a UART responder with random tx_done latency,
// a byte-stream reference model that queues the expected bytes, frame_done
// pulses and tx_err pulses, and a monitor that checks the DUT against them.
`timescale 1ns/1ps
module tb_conv16to8bit;

    localparam logic [7:0] KEY = 8'h0F;
    localparam int         DT  = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        tx_done = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        synced;
    logic        frame_done;
    logic        tx_err;

    conv16to8bit #(.KEYWORD(KEY), .DONE_TIMEOUT(16'(DT))) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_din        (din),
        .i_tx_done    (tx_done),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_synced     (synced),
        .o_frame_done (frame_done),
        .o_tx_err     (tx_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] data;
        logic       sync;
    } exp_t;

    exp_t exp_q[$];
    int   fd_q[$];
    int   err_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int n_fd = 0;
    int n_err = 0;

    // Reference model: which byte of the session is in flight.
    bit          m_busy = 1'b0;
    int          m_role = 0;        // 0 keyword, 1 high byte, 2 low byte
    int          m_start = 0;
    logic [15:0] m_word = 16'h0000;

    // UART responder.
    bit u_busy = 1'b0;
    int u_due = 0;
    bit withhold = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_word(input int c);
        m_word = din;
        exp_q.push_back('{c + 1, din[15:8], 1'b1});
        m_role = 1;
        m_start = c + 1;
    endtask

    // Given en, din and tx_done for the current cycle, decide what the
    // converter must present next cycle.
    task automatic model_step();
        int c;
        c = cyc;
        if (!m_busy) begin
            if (en) begin
                exp_q.push_back('{c + 1, KEY, 1'b0});
                m_busy = 1'b1;
                m_role = 0;
                m_start = c + 1;
            end
        end else if (tx_done && (c > m_start)) begin
            if (m_role == 0) begin
                if (en) start_word(c);
                else m_busy = 1'b0;
            end else if (m_role == 1) begin
                exp_q.push_back('{c + 1, m_word[7:0], 1'b1});
                m_role = 2;
                m_start = c + 1;
            end else begin
                fd_q.push_back(c + 1);
                if (en) start_word(c);
                else m_busy = 1'b0;
            end
        end else if (c - m_start == DT - 1) begin
            err_q.push_back(c + 1);
            m_busy = 1'b0;
        end
    endtask

    // UART responder plus model update, once per cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                tx_done = 1'b0;
                u_busy = 1'b0;
                m_busy = 1'b0;
                exp_q.delete();
                fd_q.delete();
                err_q.delete();
            end else begin
                tx_done = 1'b0;
                if (u_busy && (cyc == u_due)) begin
                    u_busy = 1'b0;
                    tx_done = !withhold;
                end
                if (tx_start) begin
                    u_busy = 1'b1;
                    u_due = cyc + int'($urandom_range(7, 1));
                    if ($urandom_range(7, 0) == 0) tx_done = 1'b1;
                end else if (!u_busy && !withhold && ($urandom_range(15, 0) == 0)) begin
                    tx_done = 1'b1;
                end
                model_step();
            end
        end
    end

    // Monitor: compares every output event against the queued expectations.
    initial begin
        exp_t       e;
        logic [7:0] last;
        last = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 8'h00;
            end else begin
                if (tx_start) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_tx_start", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("start_cycle", cyc, e.at);
                        chk("tx_data", {24'd0, tx_data}, {24'd0, e.data});
                        chk("synced_at_start", {31'd0, synced}, {31'd0, e.sync});
                    end
                    last = tx_data;
                end else begin
                    chk("tx_data_hold", {24'd0, tx_data}, {24'd0, last});
                end
                if (frame_done) begin
                    n_fd++;
                    if (fd_q.size() == 0) chk("unexpected_frame_done", 32'd1, 32'd0);
                    else chk("frame_done_cycle", cyc, fd_q.pop_front());
                end
                if (tx_err) begin
                    n_err++;
                    if (err_q.size() == 0) chk("unexpected_tx_err", 32'd1, 32'd0);
                    else chk("tx_err_cycle", cyc, err_q.pop_front());
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_start"}, {31'd0, tx_start}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
        chk({tag, "_synced"}, {31'd0, synced}, 32'd0);
        chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
        chk({tag, "_tx_err"}, {31'd0, tx_err}, 32'd0);
    endtask

    initial begin
        int k;
        int base;
        int r;

        step(3);
        chk_reset_outputs("reset");
        rst = 1'b0;
        step(1);

        // Streaming a constant word.
        din = 16'hA55A;
        en = 1'b1;
        k = 0;
        while ((n_fd < 3) && (k < 300)) begin step(1); k++; end
        chk("wait_a55a_frames", {31'd0, n_fd >= 3}, 32'd1);
        chk("synced_streaming", {31'd0, synced}, 32'd1);

        // din changes while the high byte is in flight.
        din = 16'h1234;
        k = 0;
        while (!(m_busy && (m_role == 1) && (m_word == 16'h1234)) && (k < 200)) begin step(1); k++; end
        chk("wait_msb_1234", {31'd0, m_word == 16'h1234}, 32'd1);
        din = 16'hABCD;
        k = 0;
        while (!(m_busy && (m_role == 2) && (m_word == 16'hABCD)) && (k < 200)) begin step(1); k++; end
        chk("wait_lsb_abcd", {31'd0, m_word == 16'hABCD}, 32'd1);

        // en drops during the high byte: pair completes, then idle.
        k = 0;
        while (!(m_busy && (m_role == 1)) && (k < 200)) begin step(1); k++; end
        en = 1'b0;
        k = 0;
        while (m_busy && (k < 200)) begin step(1); k++; end
        step(2);
        chk("synced_after_drop", {31'd0, synced}, 32'd0);

        // Keyword-valued data bytes.
        din = 16'h0F0F;
        en = 1'b1;
        base = n_fd;
        k = 0;
        while ((n_fd < base + 2) && (k < 300)) begin step(1); k++; end
        chk("wait_0f0f_frames", {31'd0, n_fd >= base + 2}, 32'd1);
        chk("synced_with_0f_data", {31'd0, synced}, 32'd1);

        // Watchdog expiry with tx_done withheld.
        withhold = 1'b1;
        base = n_err;
        k = 0;
        while ((n_err == base) && (k < 100)) begin step(1); k++; end
        chk("wait_tx_err", {31'd0, n_err > base}, 32'd1);
        chk("synced_after_err", {31'd0, synced}, 32'd0);
        withhold = 1'b0;
        base = n_fd;
        k = 0;
        while ((n_fd < base + 2) && (k < 300)) begin step(1); k++; end
        chk("recover_after_err", {31'd0, n_fd >= base + 2}, 32'd1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            r = int'($urandom_range(99, 0));
            if (r < 10) en = ~en;
            else if (r < 40) din = 16'($urandom);
            else if (r < 43) withhold = 1'b1;
            else if (r < 50) withhold = 1'b0;
            step(int'($urandom_range(6, 1)));
        end
        withhold = 1'b0;
        en = 1'b1;
        step(40);

        // Reset in the middle of a low byte.
        k = 0;
        while (!(m_busy && (m_role == 2)) && (k < 200)) begin step(1); k++; end
        chk("wait_mid_lsb", {31'd0, m_role == 2}, 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("async_reset");
        step(2);
        rst = 1'b0;
        base = n_fd;
        k = 0;
        while ((n_fd < base + 1) && (k < 300)) begin step(1); k++; end
        chk("restart_after_reset", {31'd0, n_fd > base}, 32'd1);

        en = 1'b0;
        step(40);
        chk("bytes_outstanding", exp_q.size(), 32'd0);
        chk("frame_done_outstanding", fd_q.size(), 32'd0);
        chk("tx_err_outstanding", err_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
